// File: rtl/sr_pulse_scheduler_pkg.sv
// Shared types and constants for the SR latch pulse scheduler.
package sr_sched_pkg;

    localparam int   CNT_W  = 4;
    localparam logic OP_SET = 1'b1;
    localparam logic OP_RST = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic logic [1:0] owner_mask(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sr_pulse_scheduler_if.sv
// Requester / latch-side signal bundle for the SR pulse scheduler.
interface sr_pulse_scheduler_if;
    logic [1:0] req;
    logic [1:0] op;
    logic       q_fb;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       err;
    logic       s;
    logic       r;
    logic       busy;

    modport master (
        output req, op, q_fb,
        input  gnt, done, err, s, r, busy
    );

    modport slave (
        input  req, op, q_fb,
        output gnt, done, err, s, r, busy
    );
endinterface

// File: rtl/sr_pulse_scheduler_rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the one not served last.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_valid,
    output logic       o_id
);
    always_comb begin
        o_valid = |i_req;
        o_id    = 1'b0;
        case (i_req)
            2'b01:   o_id = 1'b0;
            2'b10:   o_id = 1'b1;
            2'b11:   o_id = ~i_last;
            default: o_id = 1'b0;
        endcase
    end
endmodule

// File: rtl/sr_pulse_scheduler.sv
// Drives set/reset pulses onto an SR latch for two requesters, then checks q feedback.
module sr_pulse_scheduler
    import sr_sched_pkg::*;
#(
    parameter int PULSE_CYC = 3,
    parameter int GAP_CYC   = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    sr_pulse_scheduler_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for a request
    // PULSE | s or r driven for PULSE_CYC cycles
    // GAP   | s=r=0 for GAP_CYC cycles, done in the last one
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_owner;
    logic             r_op;
    logic             r_last;
    logic             r_s;
    logic             r_r;
    logic             r_busy;
    logic [1:0]       r_gnt;
    logic [1:0]       r_done;
    logic             w_valid;
    logic             w_id;

    rr_arb2 u_arb (
        .i_req   (bus.req),
        .i_last  (r_last),
        .o_valid (w_valid),
        .o_id    (w_id)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_owner <= 1'b0;
            r_op    <= OP_RST;
            r_last  <= 1'b1;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_busy  <= 1'b0;
            r_gnt   <= 2'b00;
            r_done  <= 2'b00;
        end else begin
            r_gnt  <= 2'b00;
            r_done <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_state <= ST_PULSE;
                        r_cnt   <= PULSE_LD;
                        r_owner <= w_id;
                        r_op    <= bus.op[w_id];
                        r_last  <= w_id;
                        r_gnt   <= owner_mask(w_id);
                        r_s     <= bus.op[w_id];
                        r_r     <= ~bus.op[w_id];
                        r_busy  <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_GAP;
                        r_cnt   <= GAP_LD;
                        r_s     <= 1'b0;
                        r_r     <= 1'b0;
                        // single-cycle gap: that cycle is also the final one
                        if (GAP_LD == '0) r_done <= owner_mask(r_owner);
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) r_done <= owner_mask(r_owner);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_s     <= 1'b0;
                    r_r     <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt  = r_gnt;
    assign bus.done = r_done;
    assign bus.s    = r_s;
    assign bus.r    = r_r;
    assign bus.busy = r_busy;
    // q_fb is judged in the done cycle itself, so err is gated live rather than registered
    assign bus.err  = (|r_done) & (bus.q_fb != r_op);

endmodule
